// File: rtl/gf2m_digit_serial_mult_if.sv
// Operand/result bundle for the digit-serial GF(2^m) multiplier.
// The master issues start/mac/a/b/f and the slave returns c/busy/over.
interface gf2m_digit_serial_mult_if #(
  parameter int M = 8
);
  logic         start;
  logic         mac;
  logic [M-1:0] a;
  logic [M-1:0] b;
  logic [M:0]   f;
  logic [M-1:0] c;
  logic         busy;
  logic         over;

  modport master (
    output start, mac, a, b, f,
    input  c, busy, over
  );

  modport slave (
    input  start, mac, a, b, f,
    output c, busy, over
  );
endinterface

// File: rtl/gf2m_digit_serial_mult.sv
// Digit-serial GF(2^m) multiplier with an optional multiply-accumulate mode.
// Each RUN cycle folds D bits of b into the accumulator, MSB first, using the run-time field polynomial.
module gf2m_digit_serial_mult #(
  parameter int M = 8,
  parameter int D = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  gf2m_digit_serial_mult_if.slave  bus
);

  localparam int N  = (M + D - 1) / D;
  localparam int W  = N * D;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t         state, state_d;
  logic [M-1:0]   a_q, f_q;
  logic [W-1:0]   b_q, b_ext;
  logic           mac_q;
  logic [M-1:0]   acc, acc_step, acc_d;
  logic [M-1:0]   c_q, c_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           busy_q, busy_d;
  logic           over_q, over_d;
  logic           accept;
  logic           last;

  assign accept = bus.start && (state == IDLE);
  assign last   = (cnt == LAST_CNT);

  // Pad b up to a whole number of digits; the zero top bits run first.
  always_comb begin
    b_ext        = '0;
    b_ext[M-1:0] = bus.b;
  end

  // One digit step: D chained shift/reduce/add stages, no internal registers.
  // NOTE: blocking assignments inside the loop are deliberate; each iteration
  // consumes the previous iteration's value, building a combinational chain.
  always_comb begin
    acc_step = acc;
    for (int j = 0; j < D; j++) begin
      acc_step = {acc_step[M-2:0], 1'b0} ^ (acc_step[M-1] ? f_q : '0);
      if (b_q[W-1-j]) begin
        acc_step = acc_step ^ a_q;
      end
    end
  end

  // NOTE: every variable driven here gets a default first so no path can
  // leave it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state;
    busy_d  = busy_q;
    over_d  = 1'b0;
    cnt_d   = cnt;
    acc_d   = acc;
    c_d     = c_q;
    case (state)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          busy_d  = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        acc_d = acc_step;
        cnt_d = cnt + 1'b1;
        if (last) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          over_d  = 1'b1;
          cnt_d   = '0;
          c_d     = mac_q ? (c_q ^ acc_step) : acc_step;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      over_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      c_q    <= '0;
    end else begin
      state  <= state_d;
      busy_q <= busy_d;
      over_q <= over_d;
      cnt    <= cnt_d;
      acc    <= acc_d;
      c_q    <= c_d;
    end
  end

  // NOTE: operand registers carry no reset; they are always loaded on accept
  // before the control path ever reads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= bus.a;
      f_q   <= bus.f[M-1:0];
      mac_q <= bus.mac;
      b_q   <= b_ext;
    end else if (state == RUN) begin
      b_q   <= b_q << D;
    end
  end

  assign bus.c    = c_q;
  assign bus.busy = busy_q;
  assign bus.over = over_q;

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// Scoreboard bench for gf2m_digit_serial_mult: three instances (D=4, D=1, D=3) with M=8
// and f=0x11B, directed AES-field vectors, monitor pops expected results on every over pulse.
module tb_gf2m_digit_serial_mult;

  typedef struct {
    logic [7:0] c;
    int         due;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [3];
  logic       mac_v   [3];
  logic [7:0] a_v     [3];
  logic [7:0] b_v     [3];
  logic [8:0] f_v;
  logic [7:0] c_w     [3];
  logic       busy_w  [3];
  logic       over_w  [3];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_tab [3] = '{2, 8, 3};
  exp_t exp_q [3][$];

  gf2m_digit_serial_mult_if #(.M(8)) bus4 ();
  gf2m_digit_serial_mult_if #(.M(8)) bus1 ();
  gf2m_digit_serial_mult_if #(.M(8)) bus3 ();

  assign bus4.start = start_v[0];
  assign bus4.mac   = mac_v[0];
  assign bus4.a     = a_v[0];
  assign bus4.b     = b_v[0];
  assign bus4.f     = f_v;
  assign c_w[0]     = bus4.c;
  assign busy_w[0]  = bus4.busy;
  assign over_w[0]  = bus4.over;

  assign bus1.start = start_v[1];
  assign bus1.mac   = mac_v[1];
  assign bus1.a     = a_v[1];
  assign bus1.b     = b_v[1];
  assign bus1.f     = f_v;
  assign c_w[1]     = bus1.c;
  assign busy_w[1]  = bus1.busy;
  assign over_w[1]  = bus1.over;

  assign bus3.start = start_v[2];
  assign bus3.mac   = mac_v[2];
  assign bus3.a     = a_v[2];
  assign bus3.b     = b_v[2];
  assign bus3.f     = f_v;
  assign c_w[2]     = bus3.c;
  assign busy_w[2]  = bus3.busy;
  assign over_w[2]  = bus3.over;

  gf2m_digit_serial_mult #(.M(8), .D(4)) u_d4 (.clk(clk), .rst(rst), .bus(bus4));
  gf2m_digit_serial_mult #(.M(8), .D(1)) u_d1 (.clk(clk), .rst(rst), .bus(bus1));
  gf2m_digit_serial_mult #(.M(8), .D(3)) u_d3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every over pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        check($sformatf("busy_over_exclusive_%0d", k), 32'(busy_w[k] & over_w[k]), 32'd0);
        if (over_w[k]) begin
          if (exp_q[k].size() == 0) begin
            check($sformatf("unexpected_over_%0d", k), 32'(over_w[k]), 32'd0);
          end else begin
            e = exp_q[k].pop_front();
            check({e.name, "_c"}, 32'(c_w[k]), 32'(e.c));
            check({e.name, "_latency"}, 32'(cyc), 32'(e.due));
          end
        end
      end
    end
  end

  // Called at a negedge; returns 1ns after the accepting edge.
  task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b, input logic mac,
                       input logic [7:0] c_exp, input bit expect_done, input string name);
    exp_t e;
    a_v[k]     = a;
    b_v[k]     = b;
    mac_v[k]   = mac;
    start_v[k] = 1'b1;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    if (expect_done) begin
      e.c    = c_exp;
      e.due  = cyc + n_tab[k];
      e.name = name;
      exp_q[k].push_back(e);
    end
    check({name, "_busy"}, 32'(busy_w[k]), 32'd1);
  endtask

  // Returns at the negedge of the over cycle, or flags a timeout.
  task automatic wait_done(input int k);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (over_w[k]) break;
    end
    check($sformatf("over_seen_%0d", k), 32'(over_w[k]), 32'd1);
  endtask

  logic [7:0] edge_tab [3][3];

  initial begin
    edge_tab[0] = '{8'h00, 8'hFF, 8'h00};
    edge_tab[1] = '{8'h57, 8'h01, 8'h57};
    edge_tab[2] = '{8'h80, 8'h02, 8'h1B};
    f_v = 9'h11B;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0;
      mac_v[k]   = 1'b0;
      a_v[k]     = 8'h00;
      b_v[k]     = 8'h00;
    end

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_c_%0d", k), 32'(c_w[k]), 32'd0);
      check($sformatf("reset_busy_%0d", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("reset_over_%0d", k), 32'(over_w[k]), 32'd0);
    end
    rst = 1'b0;

    // Basic product, all three digit sizes.
    @(negedge clk);
    issue(0, 8'h57, 8'h83, 1'b0, 8'hC1, 1'b1, "t1_d4");
    @(negedge clk);
    check("t1_busy_second_cycle", 32'(busy_w[0]), 32'd1);
    wait_done(0);
    @(negedge clk);
    issue(1, 8'h57, 8'h83, 1'b0, 8'hC1, 1'b1, "t2_d1");
    wait_done(1);
    @(negedge clk);
    issue(2, 8'h57, 8'h83, 1'b0, 8'hC1, 1'b1, "t2_d3");
    wait_done(2);

    // Back-to-back MAC chain issued in the over cycle.
    @(negedge clk);
    issue(0, 8'h57, 8'h83, 1'b0, 8'hC1, 1'b1, "t3_first");
    wait_done(0);
    issue(0, 8'h57, 8'h13, 1'b1, 8'h3F, 1'b1, "t3_mac");
    wait_done(0);

    // Edge operands including the reduction path.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      issue(0, edge_tab[i][0], edge_tab[i][1], 1'b0, edge_tab[i][2], 1'b1,
            $sformatf("t4_edge%0d", i));
      wait_done(0);
    end

    // start while busy must be ignored.
    @(negedge clk);
    issue(0, 8'h57, 8'h83, 1'b0, 8'hC1, 1'b1, "t5_first");
    @(negedge clk);
    a_v[0]     = 8'hFF;
    b_v[0]     = 8'hFF;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    wait_done(0);
    repeat (6) @(negedge clk);
    check("t5_c_hold", 32'(c_w[0]), 32'hC1);

    // Reset mid-operation aborts without an over pulse.
    @(negedge clk);
    issue(1, 8'h57, 8'h83, 1'b0, 8'h00, 1'b0, "t6_abort");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_rst_c", 32'(c_w[1]), 32'd0);
    check("t6_rst_busy", 32'(busy_w[1]), 32'd0);
    check("t6_rst_over", 32'(over_w[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t6_no_late_over", 32'(c_w[1]), 32'd0);
    issue(1, 8'h57, 8'h83, 1'b0, 8'hC1, 1'b1, "t6_after");
    wait_done(1);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("queue_drained_%0d", k), 32'(exp_q[k].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf2m_digit_serial_mult.md
Name: gf2m_digit_serial_mult

Overview:
Parametrised digit-serial GF(2^m) multiplier. It succeeds the fixed-width systolic multiplier: field width M and digit size D are configurable, and the field polynomial f is a run-time input. Each cycle it consumes D bits of b, MSB-first, and a start/busy/over handshake frames each operation. An optional multiply-accumulate mode (c <= c XOR a*b) serves as the building block for point-arithmetic datapaths.

Parameters:
M, 8, field degree (operand width); legal range 2 to 571.
D, 4, digit size in bits of b processed per cycle; legal range 1 to M.
N, ceil(M/D) (derived localparam), number of digit cycles.

Ports:
clk  input  1  system clock, all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
mac  input  1  sampled with start; 1 means c <= c_old XOR a*b mod f, 0 means c <= a*b mod f.
a  input  M  multiplicand in polynomial basis, bit i is the coefficient of x^i.
b  input  M  multiplier in polynomial basis.
f  input  M+1  field polynomial. f[M] and f[0] must be 1; the block uses only f[M-1:0].
c  output  M  result register; holds its value until the next completion.
busy  output  1  operation in progress.
over  output  1  one-cycle pulse; c is valid and new in this cycle.

Behaviour:
- Reset (rst=1 at an edge): state IDLE, c=0, busy=0, over=0, acc=0, digit counter=0. This applies mid-operation too: the operation is aborted with no over pulse.
- States and transitions:
  - IDLE: start=1 at edge T moves to RUN.
  - RUN: runs N digit cycles.
  - After the last digit, returns to IDLE, or re-enters RUN if start=1 in the over cycle.
- Edge T (accept):
  - Latch a, f[M-1:0] and mac.
  - Latch b zero-extended to N*D bits. The extra top bits are processed first and are harmless.
  - acc <= 0, cnt <= 0, busy <= 1.
- Edges T+1 .. T+N: one digit step each. Do D sequential bit iterations, MSB of the current digit first:
  - t = acc<<1 (M+1 bits).
  - If t[M]=1, acc' = t[M-1:0] XOR f[M-1:0], else acc' = t[M-1:0].
  - If the b bit is 1, acc' ^= a.
  - Shift the b register left by D. cnt increments.
- Edge T+N (final digit):
  - c <= result when mac=0, or c XOR result when mac=1.
  - over <= 1, busy <= 0.
- Timing:
  - over is high for exactly the cycle after edge T+N, and clears at the next edge unless a new completion occurs.
  - busy is high from edge T to edge T+N, so busy and over are never high together.
  - Latency: start sampled at edge T, result visible N cycles later. For D=M, N=1.
- start while busy=1 is ignored; it is not queued and operands are not re-latched.
- start in the over cycle is accepted (back-to-back operations, no bubble). With mac=1, this uses the just-written c.
- Input changes to a, b, f or mac after edge T have no effect on the running operation.
- Arithmetic is pure GF(2): XOR and shift only, no carries. The result is fully reduced (degree < M) for any a and b, including inputs of degree M-1.
- The critical path is D chained shift/reduce/XOR stages. No pipeline registers are inside a digit.

Test Plan:
1. M=8, D=4, f=9'h11B, a=8'h57, b=8'h83, mac=0, start pulse -> over exactly 2 cycles after the start edge, c=8'hC1, busy high for those 2 cycles.
2. M=8, D=1, same operands -> over after 8 cycles, c=8'hC1. With D=3 (N=3, one padded bit) -> over after 3 cycles, c=8'hC1.
3. MAC chain, D=4, f=11B: a=57,b=83,mac=0 gives c=C1. Then start in the over cycle with a=57, b=13, mac=1 -> second over 2 cycles later, c=8'h3F (C1 XOR FE).
4. Edge values, D=4, f=11B: a=00,b=FF -> c=00. a=57,b=01 -> c=57. a=80,b=02 -> c=1B (reduction path).
5. start pulsed again while busy with a=FF,b=FF -> ignored; the first result (C1) is unchanged and exactly one over pulse is produced.
6. rst asserted at cycle T+1 of a D=1 operation -> next cycle c=0, busy=0, over=0, and no over pulse afterwards. A new start then completes normally with c=C1.
